uart_bus_bridge: RTL and testbench
==================================

Name: uart_bus_bridge

Overview:
- UART-driven debug/loader bridge that acts as an initiator on the SoC data bus, the other end of the processor-to-memory request/response interface.
- Consumes command bytes from the buart receive side and issues word reads/writes on the data bus (dmem/IO decode) while the processor is held.
- Returns status and read data as bytes through the buart transmit side.
- Also drives a processor hold signal so host software can load a program and then release the CPU.

Parameters:
- RD_TIMEOUT, 16, cycles to wait for ip_data_valid after op_data_rd asserts before aborting the read.
- HOLD_ON_RESET, 1, value of op_cpu_hold after reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ip_uart_valid  input  1  buart has a received byte
- ip_uart_rx_data  input  8  buart received byte
- op_uart_rd  output  1  one-cycle pulse, consumes current rx byte
- ip_uart_busy  input  1  buart transmitter busy
- op_uart_wr  output  1  one-cycle pulse, starts transmit of op_uart_tx_data
- op_uart_tx_data  output  8  byte to transmit
- op_data_addr  output  32  bus word address
- op_data_wr  output  1  write strobe
- op_data_mask  output  4  byte mask, always 4'b1111 during a write
- op_data_to_mem  output  32  write data
- op_data_rd  output  1  read request
- ip_data_valid  input  1  read data valid
- ip_data_from_mem  input  32  read data
- op_cpu_hold  output  1  1 = processor held in reset
- op_active  output  1  1 while a command is in progress (state != IDLE)

Behaviour:
- Clocking and reset: one clock; reset synchronous, active-high.
- Reset values: state=IDLE; op_cpu_hold=HOLD_ON_RESET; all other outputs 0.
- Commands (multi-byte fields little-endian):
  - 'W'(0x57) + A0..A3 + D0..D3: write D to A; reply 'K'(0x4B).
  - 'R'(0x52) + A0..A3: read A; reply D0..D3; on timeout reply 'E'(0x45).
  - 'H'(0x48): set op_cpu_hold=1; reply 'K'.
  - 'G'(0x47): clear op_cpu_hold; reply 'K'.
  - Any other byte in IDLE: consumed, silently dropped, no reply.
- RX handshake:
  - In a receive state with ip_uart_valid=1: pulse op_uart_rd for one cycle and latch ip_uart_rx_data that cycle.
  - The following cycle is a gap cycle; ip_uart_valid is ignored during it.
- States:
  - IDLE -> GET_ADDR on 'W'/'R'; IDLE -> SEND on 'H'/'G'.
  - GET_ADDR: 2-bit byte counter; after 4 bytes -> GET_DATA for 'W', BUS_RD for 'R'.
  - GET_DATA: 4 bytes, then -> BUS_WR.
  - BUS_WR: op_data_wr=1 and op_data_mask=4'b1111 for exactly one cycle; op_data_addr and op_data_to_mem stable that cycle; then -> SEND with reply 'K'.
  - BUS_RD: op_data_rd held high with op_data_addr stable until ip_data_valid=1. Valid in the same cycle rd is first asserted is accepted. Latch ip_data_from_mem, drop rd the next cycle, -> SEND with 4 bytes. If RD_TIMEOUT cycles elapse without valid, drop rd and -> SEND with 'E'.
  - SEND: reply register (up to 4 bytes) plus count. When ip_uart_busy=0, pulse op_uart_wr one cycle with the low byte, shift right by 8, decrement count. Skip one cycle before sampling busy again. Count reaching 0 -> IDLE.
- op_data_wr and op_data_rd are never asserted together and are never asserted outside BUS_WR/BUS_RD.
- Bus accesses are issued regardless of op_cpu_hold; keeping the CPU off the bus is the host's responsibility.
- Addresses with bit31=1 reach the IO decode normally, so UART registers are accessible.
- Reset mid-command: returns to IDLE next cycle. Partial fields are discarded; any in-flight rd/wr deasserts.
- No command timeout on RX; an idle host simply leaves the bridge waiting.

Optional Feature:
- Macro: UART_BRIDGE_CHECKSUM_EN.
- When defined:
  - 'W' and 'R' carry one trailing checksum byte (state GET_CSUM) equal to XOR of all preceding bytes including the opcode.
  - On mismatch: no bus access; reply 'E'.
  - 'H'/'G' are unaffected.
- When undefined: no checksum byte; GET_CSUM does not exist.

Test Plan:
- Write: send 57 10 00 00 00 EF BE AD DE -> one-cycle op_data_wr, addr 0x00000010, data 0xDEADBEEF, mask 4'hF; tx 0x4B.
- Read: send 52 10 00 00 00; memory returns 0xDEADBEEF with valid 3 cycles later -> op_data_rd held 4 cycles; tx EF BE AD DE in order.
- Timeout: read with ip_data_valid tied 0, RD_TIMEOUT=16 -> op_data_rd high exactly 16 cycles; tx 0x45.
- Hold/Go: after reset, op_cpu_hold=1; send 47 -> op_cpu_hold=0 and tx 4B; send 48 -> op_cpu_hold=1 and tx 4B; byte 0x00 -> no tx, stays IDLE.
- Reset mid-command: send 57 10 00, assert reset 1 cycle, then send a full 'R' -> the 'R' executes correctly with no stray write.
- Checksum (macro on): 52 10 00 00 00 42 -> read executes; with 43 as the last byte instead -> tx 0x45, no op_data_rd.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART-driven debug/loader initiator on the SoC data bus.
// Host bytes arrive from the buart receiver and become word reads/writes.
// Status and read data go back through the buart transmitter.
// The bridge also owns the processor hold line so a host can load code and release the CPU.
// Optional build macro UART_BRIDGE_CHECKSUM_EN: 'W'/'R' carry a trailing XOR checksum byte.
// All outputs are registered. A received byte is consumed in the cycle op_uart_rd is high,
// and that cycle is followed by one gap cycle.
module uart_bus_bridge #(
  parameter int unsigned RD_TIMEOUT    = 16,
  parameter logic        HOLD_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_uart_valid,
  input  logic [7:0]  ip_uart_rx_data,
  output logic        op_uart_rd,
  input  logic        ip_uart_busy,
  output logic        op_uart_wr,
  output logic [7:0]  op_uart_tx_data,
  output logic [31:0] op_data_addr,
  output logic        op_data_wr,
  output logic [3:0]  op_data_mask,
  output logic [31:0] op_data_to_mem,
  output logic        op_data_rd,
  input  logic        ip_data_valid,
  input  logic [31:0] ip_data_from_mem,
  output logic        op_cpu_hold,
  output logic        op_active
);

  localparam int unsigned TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_ADDR = 3'd1;
  localparam logic [2:0] ST_GET_DATA = 3'd2;
`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam logic [2:0] ST_GET_CSUM = 3'd3;
`endif
  localparam logic [2:0] ST_BUS_WR   = 3'd4;
  localparam logic [2:0] ST_BUS_RD   = 3'd5;
  localparam logic [2:0] ST_SEND     = 3'd6;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_HOLD  = 8'h48;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  logic [2:0]       state, state_nxt;
  logic             gap, gap_nxt;
  logic             is_wr, is_wr_nxt;
  logic [1:0]       bcnt, bcnt_nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt;
  logic [31:0]      reply, reply_nxt;
  logic [2:0]       send_cnt, send_cnt_nxt;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0]       csum, csum_nxt;
`endif

  logic             uart_rd_nxt, uart_wr_nxt, data_wr_nxt, data_rd_nxt, hold_nxt, active_nxt;
  logic [7:0]       tx_data_nxt;
  logic [31:0]      addr_nxt, wdata_nxt;
  logic [3:0]       mask_nxt;
  logic             rx_state;
  logic [7:0]       rx_byte;

  // Next-state, handshake and datapath decode
  always_comb begin
    state_nxt    = state;
    gap_nxt      = 1'b0;
    is_wr_nxt    = is_wr;
    bcnt_nxt     = bcnt;
    tmo_nxt      = tmo;
    reply_nxt    = reply;
    send_cnt_nxt = send_cnt;
`ifdef UART_BRIDGE_CHECKSUM_EN
    csum_nxt     = csum;
`endif
    uart_rd_nxt  = 1'b0;
    uart_wr_nxt  = 1'b0;
    tx_data_nxt  = op_uart_tx_data;
    addr_nxt     = op_data_addr;
    wdata_nxt    = op_data_to_mem;
    data_wr_nxt  = 1'b0;
    mask_nxt     = 4'h0;
    data_rd_nxt  = op_data_rd;
    hold_nxt     = op_cpu_hold;
    rx_byte      = ip_uart_rx_data;

    rx_state = (state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA);
`ifdef UART_BRIDGE_CHECKSUM_EN
    rx_state = rx_state || (state == ST_GET_CSUM);
`endif

    // Arm the consume pulse; the byte is taken while op_uart_rd is high, then one gap cycle
    uart_rd_nxt = rx_state && ip_uart_valid && !op_uart_rd && !gap;
    gap_nxt     = op_uart_rd;

    case (state)
      ST_IDLE: begin
        if (op_uart_rd) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
          csum_nxt = rx_byte;
`endif
          case (rx_byte)
            CMD_WRITE, CMD_READ: begin
              is_wr_nxt = (rx_byte == CMD_WRITE);
              bcnt_nxt  = 2'd0;
              state_nxt = ST_GET_ADDR;
            end
            CMD_HOLD, CMD_GO: begin
              hold_nxt     = (rx_byte == CMD_HOLD);
              reply_nxt    = 32'(RSP_OK);
              send_cnt_nxt = 3'd1;
              state_nxt    = ST_SEND;
            end
            default: ;
          endcase
        end
      end

      ST_GET_ADDR: begin
        if (op_uart_rd) begin
          addr_nxt = {rx_byte, op_data_addr[31:8]};
          bcnt_nxt = bcnt + 2'd1;
`ifdef UART_BRIDGE_CHECKSUM_EN
          csum_nxt = csum ^ rx_byte;
`endif
          if (bcnt == 2'd3) begin
            if (is_wr) begin
              state_nxt = ST_GET_DATA;
            end else begin
`ifdef UART_BRIDGE_CHECKSUM_EN
              state_nxt = ST_GET_CSUM;
`else
              state_nxt   = ST_BUS_RD;
              data_rd_nxt = 1'b1;
              tmo_nxt     = '0;
`endif
            end
          end
        end
      end

      ST_GET_DATA: begin
        if (op_uart_rd) begin
          wdata_nxt = {rx_byte, op_data_to_mem[31:8]};
          bcnt_nxt  = bcnt + 2'd1;
`ifdef UART_BRIDGE_CHECKSUM_EN
          csum_nxt  = csum ^ rx_byte;
`endif
          if (bcnt == 2'd3) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            state_nxt = ST_GET_CSUM;
`else
            state_nxt   = ST_BUS_WR;
            data_wr_nxt = 1'b1;
            mask_nxt    = 4'hF;
`endif
          end
        end
      end

`ifdef UART_BRIDGE_CHECKSUM_EN
      ST_GET_CSUM: begin
        if (op_uart_rd) begin
          if (rx_byte != csum) begin
            reply_nxt    = 32'(RSP_ERR);
            send_cnt_nxt = 3'd1;
            state_nxt    = ST_SEND;
          end else if (is_wr) begin
            state_nxt   = ST_BUS_WR;
            data_wr_nxt = 1'b1;
            mask_nxt    = 4'hF;
          end else begin
            state_nxt   = ST_BUS_RD;
            data_rd_nxt = 1'b1;
            tmo_nxt     = '0;
          end
        end
      end
`endif

      // Write strobe is high for exactly this cycle
      ST_BUS_WR: begin
        reply_nxt    = 32'(RSP_OK);
        send_cnt_nxt = 3'd1;
        state_nxt    = ST_SEND;
      end

      ST_BUS_RD: begin
        if (ip_data_valid) begin
          data_rd_nxt  = 1'b0;
          reply_nxt    = ip_data_from_mem;
          send_cnt_nxt = 3'd4;
          state_nxt    = ST_SEND;
        end else if (tmo == TMO_W'(RD_TIMEOUT - 1)) begin
          data_rd_nxt  = 1'b0;
          reply_nxt    = 32'(RSP_ERR);
          send_cnt_nxt = 3'd1;
          state_nxt    = ST_SEND;
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
        end
      end

      // One byte per pulse; the cycle after a pulse is skipped before busy is trusted again
      ST_SEND: begin
        if (!ip_uart_busy && !op_uart_wr) begin
          uart_wr_nxt  = 1'b1;
          tx_data_nxt  = reply[7:0];
          reply_nxt    = {8'h00, reply[31:8]};
          send_cnt_nxt = send_cnt - 3'd1;
          if (send_cnt == 3'd1) state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    active_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      gap             <= 1'b0;
      is_wr           <= 1'b0;
      bcnt            <= 2'd0;
      tmo             <= '0;
      reply           <= 32'h0;
      send_cnt        <= 3'd0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum            <= 8'h00;
`endif
      op_uart_rd      <= 1'b0;
      op_uart_wr      <= 1'b0;
      op_uart_tx_data <= 8'h00;
      op_data_addr    <= 32'h0;
      op_data_wr      <= 1'b0;
      op_data_mask    <= 4'h0;
      op_data_to_mem  <= 32'h0;
      op_data_rd      <= 1'b0;
      op_cpu_hold     <= HOLD_ON_RESET;
      op_active       <= 1'b0;
    end else begin
      state           <= state_nxt;
      gap             <= gap_nxt;
      is_wr           <= is_wr_nxt;
      bcnt            <= bcnt_nxt;
      tmo             <= tmo_nxt;
      reply           <= reply_nxt;
      send_cnt        <= send_cnt_nxt;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum            <= csum_nxt;
`endif
      op_uart_rd      <= uart_rd_nxt;
      op_uart_wr      <= uart_wr_nxt;
      op_uart_tx_data <= tx_data_nxt;
      op_data_addr    <= addr_nxt;
      op_data_wr      <= data_wr_nxt;
      op_data_mask    <= mask_nxt;
      op_data_to_mem  <= wdata_nxt;
      op_data_rd      <= data_rd_nxt;
      op_cpu_hold     <= hold_nxt;
      op_active       <= active_nxt;
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: table of host commands with expected replies and bus activity,
// plus hand-written reset-mid-command and checksum sequences.
module tb_uart_bus_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ip_uart_valid = 1'b0;
  logic [7:0]  ip_uart_rx_data = 8'h00;
  logic        op_uart_rd;
  logic        ip_uart_busy = 1'b0;
  logic        op_uart_wr;
  logic [7:0]  op_uart_tx_data;
  logic [31:0] op_data_addr;
  logic        op_data_wr;
  logic [3:0]  op_data_mask;
  logic [31:0] op_data_to_mem;
  logic        op_data_rd;
  logic        ip_data_valid = 1'b0;
  logic [31:0] ip_data_from_mem = 32'h0;
  logic        op_cpu_hold;
  logic        op_active;

  always #5 clk = ~clk;

  uart_bus_bridge #(.RD_TIMEOUT(16), .HOLD_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ip_uart_valid(ip_uart_valid), .ip_uart_rx_data(ip_uart_rx_data), .op_uart_rd(op_uart_rd),
    .ip_uart_busy(ip_uart_busy), .op_uart_wr(op_uart_wr), .op_uart_tx_data(op_uart_tx_data),
    .op_data_addr(op_data_addr), .op_data_wr(op_data_wr), .op_data_mask(op_data_mask),
    .op_data_to_mem(op_data_to_mem), .op_data_rd(op_data_rd),
    .ip_data_valid(ip_data_valid), .ip_data_from_mem(ip_data_from_mem),
    .op_cpu_hold(op_cpu_hold), .op_active(op_active)
  );

  typedef struct {
    int          n_rx;
    logic [71:0] rx;      // byte i at [8*i +: 8]
    int          n_tx;
    logic [31:0] tx;      // expected reply, first byte in [7:0]
    int          delay;   // read response latency in cycles, -1 = never
    logic [31:0] mem;
    int          n_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          rd_cyc;
    logic        hold;
  } vec_t;

  int checks = 0;
  int fails = 0;
  int proto_fails = 0;

  logic [7:0]  tx_log [$];
  int          wr_total = 0;
  int          rd_total = 0;
  logic [31:0] wr_addr_last = 32'h0;
  logic [31:0] wr_data_last = 32'h0;
  logic [3:0]  wr_mask_last = 4'h0;
  logic [31:0] rd_addr_last = 32'h0;
  int          busy_left = 0;
  logic        prev_wr = 1'b0;
  logic        prev_uwr = 1'b0;
  logic        prev_urd = 1'b0;

  int          resp_delay = -1;
  logic [31:0] mem_word = 32'h0;
  int          rd_age = 0;

  // Observe DUT outputs mid-cycle; model the buart transmitter busy window
  always @(negedge clk) begin
    if (op_uart_wr) begin
      tx_log.push_back(op_uart_tx_data);
      if (busy_left != 0 || prev_uwr) begin
        proto_fails++;
        $display("FAIL uart_wr_while_busy actual=1 required=0 t=%0t", $time);
      end
    end
    if (op_data_wr) begin
      wr_total++;
      wr_addr_last = op_data_addr;
      wr_data_last = op_data_to_mem;
      wr_mask_last = op_data_mask;
    end
    if (op_data_rd) begin
      rd_total++;
      rd_addr_last = op_data_addr;
    end
    if (op_data_wr && op_data_rd) begin
      proto_fails++;
      $display("FAIL rd_wr_overlap actual=1 required=0 t=%0t", $time);
    end
    if (op_data_wr && prev_wr) begin
      proto_fails++;
      $display("FAIL wr_pulse_width actual=2 required=1 t=%0t", $time);
    end
    if (op_uart_rd && prev_urd) begin
      proto_fails++;
      $display("FAIL uart_rd_pulse_width actual=2 required=1 t=%0t", $time);
    end
    prev_wr  = op_data_wr;
    prev_uwr = op_uart_wr;
    prev_urd = op_uart_rd;
    if (op_uart_wr) busy_left = 4;
    else if (busy_left > 0) busy_left--;
    ip_uart_busy = (busy_left != 0);
  end

  // Memory responder: valid arrives resp_delay cycles after rd first goes high
  always @(negedge clk) begin
    if (op_data_rd) begin
      ip_data_valid    = (resp_delay >= 0) && (rd_age == resp_delay);
      ip_data_from_mem = mem_word;
      rd_age++;
    end else begin
      ip_data_valid = 1'b0;
      rd_age = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    ip_uart_rx_data = b;
    ip_uart_valid = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (op_uart_rd) seen = 1'b1;
    end
    check("rx_consume", 32'(seen), 32'd1);
    @(negedge clk);
    ip_uart_valid = 1'b0;
  endtask

  task automatic wait_idle(input int tgt);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (tx_log.size() >= tgt && !op_active) done = 1'b1;
    end
    check("wait_idle", 32'(done), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  function automatic vec_t mk(input int n_rx, input logic [71:0] rx, input int n_tx,
                              input logic [31:0] tx, input int delay, input logic [31:0] mem,
                              input int n_wr, input logic [31:0] addr, input logic [31:0] data,
                              input int rd_cyc, input logic hold);
    vec_t v;
    v.n_rx = n_rx; v.rx = rx; v.n_tx = n_tx; v.tx = tx; v.delay = delay; v.mem = mem;
    v.n_wr = n_wr; v.addr = addr; v.data = data; v.rd_cyc = rd_cyc; v.hold = hold;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int base_tx, base_wr, base_rd;
    logic [7:0] cs;
    logic [7:0] b;
    base_tx = tx_log.size();
    base_wr = wr_total;
    base_rd = rd_total;
    resp_delay = v.delay;
    mem_word = v.mem;
    cs = 8'h00;
    for (int i = 0; i < v.n_rx; i++) begin
      b = v.rx[8*i +: 8];
      cs = cs ^ b;
      send_byte(b);
    end
`ifdef UART_BRIDGE_CHECKSUM_EN
    b = v.rx[7:0];
    if (b == 8'h57 || b == 8'h52) send_byte(cs);
`endif
    wait_idle(base_tx + v.n_tx);
    check("tx_count", 32'(tx_log.size() - base_tx), 32'(v.n_tx));
    for (int i = 0; i < v.n_tx; i++) begin
      if (tx_log.size() > base_tx + i) check("tx_byte", 32'(tx_log[base_tx + i]), 32'(v.tx[8*i +: 8]));
    end
    check("wr_count", 32'(wr_total - base_wr), 32'(v.n_wr));
    if (v.n_wr > 0) begin
      check("wr_addr", wr_addr_last, v.addr);
      check("wr_data", wr_data_last, v.data);
      check("wr_mask", 32'(wr_mask_last), 32'hF);
    end
    check("rd_cycles", 32'(rd_total - base_rd), 32'(v.rd_cyc));
    if (v.rd_cyc > 0) check("rd_addr", rd_addr_last, v.addr);
    check("cpu_hold", 32'(op_cpu_hold), 32'(v.hold));
    check("active_idle", 32'(op_active), 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    int snap_wr, base_tx, base_rd;

    vecs[0] = mk(9, 72'hDEADBEEF_00000010_57, 1, 32'h4B, -1, 32'h0, 1, 32'h10, 32'hDEADBEEF, 0, 1'b1);
    vecs[1] = mk(5, 72'h00000010_52, 4, 32'hDEADBEEF, 3, 32'hDEADBEEF, 0, 32'h10, 32'h0, 4, 1'b1);
    vecs[2] = mk(5, 72'h00000020_52, 1, 32'h45, -1, 32'h0, 0, 32'h20, 32'h0, 16, 1'b1);
    vecs[3] = mk(1, 72'h47, 1, 32'h4B, -1, 32'h0, 0, 32'h0, 32'h0, 0, 1'b0);
    vecs[4] = mk(1, 72'h48, 1, 32'h4B, -1, 32'h0, 0, 32'h0, 32'h0, 0, 1'b1);
    vecs[5] = mk(1, 72'h00, 0, 32'h0, -1, 32'h0, 0, 32'h0, 32'h0, 0, 1'b1);
    vecs[6] = mk(1, 72'h47, 1, 32'h4B, -1, 32'h0, 0, 32'h0, 32'h0, 0, 1'b0);
    vecs[7] = mk(9, 72'h12345678_80000004_57, 1, 32'h4B, -1, 32'h0, 1, 32'h80000004, 32'h12345678, 0, 1'b0);
    vecs[8] = mk(5, 72'h80000004_52, 4, 32'hA5A55A5A, 0, 32'hA5A55A5A, 0, 32'h80000004, 32'h0, 1, 1'b0);
    vecs[9] = mk(1, 72'h48, 1, 32'h4B, -1, 32'h0, 0, 32'h0, 32'h0, 0, 1'b1);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_uart_rd", 32'(op_uart_rd), 32'd0);
    check("rst_uart_wr", 32'(op_uart_wr), 32'd0);
    check("rst_tx_data", 32'(op_uart_tx_data), 32'd0);
    check("rst_addr", op_data_addr, 32'd0);
    check("rst_data_wr", 32'(op_data_wr), 32'd0);
    check("rst_mask", 32'(op_data_mask), 32'd0);
    check("rst_to_mem", op_data_to_mem, 32'd0);
    check("rst_data_rd", 32'(op_data_rd), 32'd0);
    check("rst_cpu_hold", 32'(op_cpu_hold), 32'd1);
    check("rst_active", 32'(op_active), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset in the middle of a write; the following read must run cleanly with no write
    run_vec(mk(1, 72'h47, 1, 32'h4B, -1, 32'h0, 0, 32'h0, 32'h0, 0, 1'b0));
    snap_wr = wr_total;
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_active", 32'(op_active), 32'd0);
    check("midrst_hold", 32'(op_cpu_hold), 32'd1);
    run_vec(mk(5, 72'h00000044_52, 4, 32'hCAFEF00D, 2, 32'hCAFEF00D, 0, 32'h44, 32'h0, 3, 1'b1));
    check("midrst_no_write", 32'(wr_total - snap_wr), 32'd0);

`ifdef UART_BRIDGE_CHECKSUM_EN
    // Bad checksum: error reply, no bus access
    base_tx = tx_log.size();
    base_rd = rd_total;
    snap_wr = wr_total;
    send_byte(8'h52);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h43);
    wait_idle(base_tx + 1);
    check("csum_bad_tx_n", 32'(tx_log.size() - base_tx), 32'd1);
    if (tx_log.size() > base_tx) check("csum_bad_tx", 32'(tx_log[base_tx]), 32'h45);
    check("csum_bad_no_rd", 32'(rd_total - base_rd), 32'd0);
    check("csum_bad_no_wr", 32'(wr_total - snap_wr), 32'd0);
`else
    base_tx = 0;
    base_rd = 0;
`endif

    check("protocol", 32'(proto_fails), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
